// File: rtl/writeback_stage_if.sv
// Writeback stage control-word layout and the mem->wb bundle.
// The package fixes the control bit positions shared with earlier stages.

package wb_pkg;
    localparam int CONTROL_BITS   = 8;
    localparam int MEM_READ       = 0;
    localparam int LINK           = 1;
    localparam int REG_WE         = 2;
    localparam int ACCESS_SIZE_B1 = 3;
    localparam int ACCESS_SIZE_B2 = 4;
    localparam int LOAD_UNSIGNED  = 5;

    typedef struct packed {
        logic        valid;
        logic [0:4]  rd;
        logic [0:31] data;
    } fwd_t;
endpackage

interface writeback_stage_if #(
    parameter int CNT_W = 32
);
    import wb_pkg::*;

    logic                    valid_in;
    logic [0:31]             mem_data_in;
    logic [0:31]             rd_data_in;
    logic [0:4]              rd_in;
    logic [0:CONTROL_BITS-1] control_in;

    logic                    rf_we;
    logic [0:4]              rf_waddr;
    logic [0:31]             rf_wdata;

    logic                    fwd0_valid;
    logic [0:4]              fwd0_rd;
    logic [0:31]             fwd0_data;
    logic                    fwd1_valid;
    logic [0:4]              fwd1_rd;
    logic [0:31]             fwd1_data;

    logic [0:CNT_W-1]        retire_count;
    logic [0:CNT_W-1]        load_count;
    logic                    misaligned_load;

    modport master (
        output valid_in, mem_data_in, rd_data_in, rd_in, control_in,
        input  rf_we, rf_waddr, rf_wdata,
        input  fwd0_valid, fwd0_rd, fwd0_data,
        input  fwd1_valid, fwd1_rd, fwd1_data,
        input  retire_count, load_count, misaligned_load
    );

    modport slave (
        input  valid_in, mem_data_in, rd_data_in, rd_in, control_in,
        output rf_we, rf_waddr, rf_wdata,
        output fwd0_valid, fwd0_rd, fwd0_data,
        output fwd1_valid, fwd1_rd, fwd1_data,
        output retire_count, load_count, misaligned_load
    );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: load extraction, register-file write port,
// two-deep forwarding history, retire/load counters, misalign flag.

module writeback_stage #(
    parameter int CNT_W = 32
) (
    input logic              clk,
    input logic              reset,
    writeback_stage_if.slave wb
);
    import wb_pkg::*;

    localparam logic [0:CNT_W-1] CNT_ONE = CNT_W'(1);

    logic             mem_read;
    logic             reg_we;
    logic             is_byte;
    logic             ld_unsigned;
    logic [0:1]       off;
    logic             bad;
    logic             wr;

    logic [0:7]       ld_byte;
    logic [0:31]      ld_ext;
    logic [0:31]      data;

    logic             rf_we_q,    rf_we_d;
    logic [0:4]       rf_waddr_q, rf_waddr_d;
    logic [0:31]      rf_wdata_q, rf_wdata_d;
    fwd_t             fwd1_q,     fwd1_d;
    logic [0:CNT_W-1] retire_q,   retire_d;
    logic [0:CNT_W-1] load_q,     load_d;
    logic             mis_q,      mis_d;

    // LINK needs no special path: rd_data_in already carries PC+8.
    logic unused_ctrl;
    assign unused_ctrl = ^{wb.control_in[LINK],
                           wb.control_in[CONTROL_BITS-2:CONTROL_BITS-1]};

    // Decode control word and qualify the register write.
    always_comb begin
        mem_read    = wb.control_in[MEM_READ];
        reg_we      = wb.control_in[REG_WE];
        ld_unsigned = wb.control_in[LOAD_UNSIGNED];
        is_byte     = ~wb.control_in[ACCESS_SIZE_B1]
                    &  wb.control_in[ACCESS_SIZE_B2];
        off         = wb.rd_data_in[30:31];
        bad         = mem_read & ~is_byte & (off != 2'b00);
        wr          = wb.valid_in & reg_we
                    & (wb.rd_in != 5'd0) & ~bad;
    end

    // Pick the big-endian byte lane and build the writeback data.
    always_comb begin
        ld_byte = wb.mem_data_in[0:7];
        unique case (off)
            2'd0: ld_byte = wb.mem_data_in[0:7];
            2'd1: ld_byte = wb.mem_data_in[8:15];
            2'd2: ld_byte = wb.mem_data_in[16:23];
            2'd3: ld_byte = wb.mem_data_in[24:31];
        endcase
        if (ld_unsigned)
            ld_ext = {24'b0, ld_byte};
        else
            ld_ext = {{24{ld_byte[0]}}, ld_byte};
        if (!mem_read)
            data = wb.rd_data_in;
        else if (is_byte)
            data = ld_ext;
        else
            data = wb.mem_data_in;
    end

    // Next-state for write port, history and bookkeeping.
    always_comb begin
        rf_we_d    = wr;
        rf_waddr_d = wb.rd_in;
        rf_wdata_d = data;
        fwd1_d     = '{valid: rf_we_q, rd: rf_waddr_q, data: rf_wdata_q};
        retire_d   = retire_q;
        load_d     = load_q;
        mis_d      = mis_q;
        if (wb.valid_in) begin
            retire_d = retire_q + CNT_ONE;
            if (mem_read)
                load_d = load_q + CNT_ONE;
            if (bad)
                mis_d = 1'b1;
        end
    end

    // State registers; async reset clears every output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            fwd1_q     <= '0;
            retire_q   <= '0;
            load_q     <= '0;
            mis_q      <= 1'b0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            fwd1_q     <= fwd1_d;
            retire_q   <= retire_d;
            load_q     <= load_d;
            mis_q      <= mis_d;
        end
    end

    // The newest history entry is the write port itself.
    always_comb begin
        wb.rf_we           = rf_we_q;
        wb.rf_waddr        = rf_waddr_q;
        wb.rf_wdata        = rf_wdata_q;
        wb.fwd0_valid      = rf_we_q;
        wb.fwd0_rd         = rf_waddr_q;
        wb.fwd0_data       = rf_wdata_q;
        wb.fwd1_valid      = fwd1_q.valid;
        wb.fwd1_rd         = fwd1_q.rd;
        wb.fwd1_data       = fwd1_q.data;
        wb.retire_count    = retire_q;
        wb.load_count      = load_q;
        wb.misaligned_load = mis_q;
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with a behavioural model
// checked every cycle, plus literal spot checks.

module tb_writeback_stage;
    import wb_pkg::*;

    localparam int CW   = 4;
    localparam int MASK = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic run = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    writeback_stage_if #(.CNT_W(CW)) wb ();

    writeback_stage #(.CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wb)
    );

    // ---------------- model ----------------
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_f1v;
    logic [4:0]  m_f1rd;
    logic [31:0] m_f1d;
    int          m_ret;
    int          m_ld;
    logic        m_mis;

    function automatic logic [31:0] exp_data(
        input logic [31:0] mem, input logic [31:0] addr,
        input logic [0:CONTROL_BITS-1] c);
        logic [7:0] b;
        int sh;
        if (!c[MEM_READ]) return addr;
        if (!c[ACCESS_SIZE_B1] && c[ACCESS_SIZE_B2]) begin
            sh = 8 * (3 - int'(addr % 4));
            b = 8'((mem >> sh) & 32'hFF);
            if (c[LOAD_UNSIGNED]) return {24'h0, b};
            return {{24{b[7]}}, b};
        end
        return mem;
    endfunction

    function automatic logic is_bad(
        input logic [31:0] addr, input logic [0:CONTROL_BITS-1] c);
        logic byte_sz;
        byte_sz = !c[ACCESS_SIZE_B1] && c[ACCESS_SIZE_B2];
        return c[MEM_READ] && !byte_sz && (addr % 4 != 0);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_we <= 0; m_addr <= 0; m_data <= 0;
            m_f1v <= 0; m_f1rd <= 0; m_f1d <= 0;
            m_ret <= 0; m_ld <= 0; m_mis <= 0;
        end else begin
            m_f1v  <= m_we;
            m_f1rd <= m_addr;
            m_f1d  <= m_data;
            m_addr <= wb.rd_in;
            m_data <= exp_data(wb.mem_data_in, wb.rd_data_in, wb.control_in);
            m_we   <= wb.valid_in && wb.control_in[REG_WE]
                      && wb.rd_in != 0
                      && !is_bad(wb.rd_data_in, wb.control_in);
            if (wb.valid_in) begin
                m_ret <= m_ret + 1;
                if (wb.control_in[MEM_READ]) m_ld <= m_ld + 1;
                if (is_bad(wb.rd_data_in, wb.control_in)) m_mis <= 1;
            end
        end
    end

    task automatic chk(input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (run) begin
            chk("m.rf_we", 32'(wb.rf_we), 32'(m_we));
            if (m_we) begin
                chk("m.rf_waddr", 32'(wb.rf_waddr), 32'(m_addr));
                chk("m.rf_wdata", 32'(wb.rf_wdata), m_data);
            end
            chk("m.fwd0_valid", 32'(wb.fwd0_valid), 32'(m_we));
            chk("m.fwd1_valid", 32'(wb.fwd1_valid), 32'(m_f1v));
            if (m_f1v) begin
                chk("m.fwd1_rd", 32'(wb.fwd1_rd), 32'(m_f1rd));
                chk("m.fwd1_data", 32'(wb.fwd1_data), m_f1d);
            end
            chk("m.retire", 32'(wb.retire_count), 32'(m_ret & MASK));
            chk("m.loads", 32'(wb.load_count), 32'(m_ld & MASK));
            chk("m.misalign", 32'(wb.misaligned_load), 32'(m_mis));
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [0:CONTROL_BITS-1] ctl(
        input logic mr, input logic lk, input logic we,
        input logic b1, input logic b2, input logic un);
        logic [0:CONTROL_BITS-1] c;
        c = '0;
        c[MEM_READ] = mr;
        c[LINK] = lk;
        c[REG_WE] = we;
        c[ACCESS_SIZE_B1] = b1;
        c[ACCESS_SIZE_B2] = b2;
        c[LOAD_UNSIGNED] = un;
        return c;
    endfunction

    // Called just after a negedge; returns after the next negedge.
    task automatic step(input logic v, input logic [31:0] mem,
                        input logic [31:0] addr, input logic [4:0] rd,
                        input logic [0:CONTROL_BITS-1] c);
        wb.valid_in    = v;
        wb.mem_data_in = mem;
        wb.rd_data_in  = addr;
        wb.rd_in       = rd;
        wb.control_in  = c;
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".rf_we"}, 32'(wb.rf_we), 0);
        chk({tag, ".rf_wdata"}, 32'(wb.rf_wdata), 0);
        chk({tag, ".fwd0"}, 32'({wb.fwd0_valid, wb.fwd0_rd}), 0);
        chk({tag, ".fwd1"}, 32'({wb.fwd1_valid, wb.fwd1_rd}), 0);
        chk({tag, ".fwd1_data"}, 32'(wb.fwd1_data), 0);
        chk({tag, ".retire"}, 32'(wb.retire_count), 0);
        chk({tag, ".loads"}, 32'(wb.load_count), 0);
        chk({tag, ".mis"}, 32'(wb.misaligned_load), 0);
    endtask

    logic [0:CONTROL_BITS-1] ALU, LBS, LBU, LW, LNK, NOWE;

    initial begin
        ALU  = ctl(0, 0, 1, 0, 0, 0);
        LBS  = ctl(1, 0, 1, 0, 1, 0);
        LBU  = ctl(1, 0, 1, 0, 1, 1);
        LW   = ctl(1, 0, 1, 1, 0, 0);
        LNK  = ctl(0, 1, 1, 0, 0, 0);
        NOWE = ctl(0, 0, 0, 0, 0, 0);
        wb.valid_in = 0; wb.mem_data_in = 0; wb.rd_data_in = 0;
        wb.rd_in = 0; wb.control_in = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset = 0;
        run = 1;

        // ALU write
        step(1, 0, 32'h12345678, 5, ALU);
        chk("alu.we", 32'(wb.rf_we), 1);
        chk("alu.waddr", 32'(wb.rf_waddr), 5);
        chk("alu.wdata", 32'(wb.rf_wdata), 32'h12345678);
        chk("alu.fwd0", 32'({wb.fwd0_valid, wb.fwd0_rd}), 32'h25);
        chk("alu.fwd0d", 32'(wb.fwd0_data), 32'h12345678);

        // byte loads
        step(1, 32'h11A23344, 32'h00000101, 3, LBS);
        chk("lb.s1", 32'(wb.rf_wdata), 32'hFFFFFFA2);
        step(1, 32'h11A23344, 32'h00000101, 3, LBU);
        chk("lbu.1", 32'(wb.rf_wdata), 32'h000000A2);
        step(1, 32'h11A23344, 32'h00000103, 3, LBU);
        chk("lbu.3", 32'(wb.rf_wdata), 32'h00000044);
        step(1, 32'h81A23344, 32'h00000100, 3, LBS);
        chk("lb.s0", 32'(wb.rf_wdata), 32'hFFFFFF81);
        step(1, 32'h11A23344, 32'h00000102, 3, LBS);
        chk("lb.s2", 32'(wb.rf_wdata), 32'h00000033);
        chk("lb.loads", 32'(wb.load_count), 5);

        // misaligned word load, then aligned word load
        step(1, 32'hCAFEF00D, 32'h00001002, 4, LW);
        chk("lw.bad.we", 32'(wb.rf_we), 0);
        chk("lw.bad.mis", 32'(wb.misaligned_load), 1);
        chk("lw.bad.ret", 32'(wb.retire_count), 7);
        chk("lw.bad.ld", 32'(wb.load_count), 6);
        step(1, 32'hDEADBEEF, 32'h00001000, 6, LW);
        chk("lw.ok.wdata", 32'(wb.rf_wdata), 32'hDEADBEEF);
        chk("lw.ok.mis", 32'(wb.misaligned_load), 1);

        // rd=0 and bubble with REG_WE
        step(1, 0, 32'h77, 0, ALU);
        chk("rd0.we", 32'(wb.rf_we), 0);
        chk("rd0.ret", 32'(wb.retire_count), 9);
        step(0, 0, 32'h77, 9, ALU);
        chk("bub.we", 32'(wb.rf_we), 0);
        chk("bub.ret", 32'(wb.retire_count), 9);

        // back-to-back r7 then bubble
        step(1, 0, 32'hA, 7, ALU);
        step(1, 0, 32'hB, 7, ALU);
        chk("r7.fwd0", 32'({wb.fwd0_valid, wb.fwd0_rd}), 32'h27);
        chk("r7.fwd0d", 32'(wb.fwd0_data), 32'hB);
        chk("r7.fwd1", 32'({wb.fwd1_valid, wb.fwd1_rd}), 32'h27);
        chk("r7.fwd1d", 32'(wb.fwd1_data), 32'hA);
        step(0, 0, 0, 0, NOWE);
        chk("r7.bub.fwd0v", 32'(wb.fwd0_valid), 0);
        chk("r7.bub.fwd1", 32'({wb.fwd1_valid, wb.fwd1_rd}), 32'h27);
        chk("r7.bub.fwd1d", 32'(wb.fwd1_data), 32'hB);

        // link
        step(1, 32'h5555AAAA, 32'h00000408, 31, LNK);
        chk("jal.we", 32'(wb.rf_we), 1);
        chk("jal.wdata", 32'(wb.rf_wdata), 32'h408);
        chk("jal.ret", 32'(wb.retire_count), 12);

        // reset between edges
        wb.valid_in = 1; wb.rd_in = 2; wb.rd_data_in = 32'h55;
        wb.control_in = ALU;
        #2 reset = 1;
        #1 chk_zero("midrst");
        @(negedge clk);
        chk_zero("midrst.hold");
        reset = 0;
        @(negedge clk);
        chk("post.we", 32'(wb.rf_we), 1);
        chk("post.wdata", 32'(wb.rf_wdata), 32'h55);
        chk("post.ret", 32'(wb.retire_count), 1);

        // wrap: 15 more retires reach 16 -> 0
        for (int i = 0; i < 15; i++) step(1, 0, i, 1, ALU);
        chk("wrap.ret", 32'(wb.retire_count), 0);
        step(1, 0, 32'h1, 1, ALU);
        chk("wrap.ret1", 32'(wb.retire_count), 1);
        chk("wrap.ld", 32'(wb.load_count), 0);

        run = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
